// File: rtl/top_core.sv
// Sample-accumulation engine: sums CGES consecutive samples of an internal
// Fibonacci LFSR per run. Define TOP_RUNNING_RESULT_EN to expose the partial sum every run cycle.
module top_core #(
    parameter int              BITS = 32,
    parameter int              CGES = 50,
    parameter logic [BITS-1:0] TAPS = 32'h8020_0003,
    parameter logic [BITS-1:0] SEED = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic                            fin,
    output logic [$clog2(CGES)+BITS-1:0]    result
);

    localparam int CW = $clog2(CGES);
    localparam int RW = CW + BITS;
    localparam logic [CW-1:0] LAST = CW'(CGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BITS-1:0] lfsr;
    logic [BITS-1:0] lfsr_next;
    logic [RW-1:0]   acc;
    logic [RW-1:0]   sum;
    logic [CW-1:0]   cnt;
    logic            load;
    logic            step;
    logic            finish;

    assign lfsr_next = {lfsr[BITS-2:0], ^(lfsr & TAPS)};
    assign sum       = acc + {{CW{1'b0}}, lfsr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // fin wins over everything; DONE waits for start to drop so a held level cannot retrigger
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !fin) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (fin) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == LAST) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (fin || !start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED;
        end else if (load) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (fin || load) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= sum;
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef TOP_RUNNING_RESULT_EN
    // Every RUN cycle publishes acc+lfsr, including the cycle an abort lands on
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (state == RUN) begin
            result <= sum;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (finish) begin
            result <= sum;
        end
    end
`endif

endmodule

// File: tb/tb_top_core.sv
// Scoreboard bench for top_core: stimulus pushes expected results with the cycle they are due,
// a negedge monitor compares; the reference sum is computed from the LFSR rule with plain arithmetic.
module tb_top_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [3:0]  start_v;
    logic [3:0]  fin_v;
    logic [37:0] res_def;
    logic [5:0]  res_b3;
    logic [7:0]  res_b15;
    logic [5:0]  res_b4;

    top_core u_def (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .fin(fin_v[0]), .result(res_def)
    );
    top_core #(.BITS(4), .CGES(3), .TAPS(4'hC), .SEED(4'h1)) u_b3 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .fin(fin_v[1]), .result(res_b3)
    );
    top_core #(.BITS(4), .CGES(15), .TAPS(4'hC), .SEED(4'h1)) u_b15 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .fin(fin_v[2]), .result(res_b15)
    );
    top_core #(.BITS(4), .CGES(4), .TAPS(4'hC), .SEED(4'h1)) u_b4 (
        .clk(clk), .reset_n(reset_n), .start(start_v[3]), .fin(fin_v[3]), .result(res_b4)
    );

    typedef struct {
        int              id;
        int              due;
        longint unsigned val;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

`ifdef TOP_RUNNING_RESULT_EN
    localparam longint unsigned ABORT_FRESH = 3;
    localparam longint unsigned ABORT_AFTER = 3;
`else
    localparam longint unsigned ABORT_FRESH = 0;
    localparam longint unsigned ABORT_AFTER = 16;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint unsigned ref_sum(int n);
        longint unsigned x = 1;
        longint unsigned s = 0;
        longint unsigned fb;
        for (int i = 0; i < n; i++) begin
            s += x;
            fb = longint'($countones(x & 64'h8020_0003) % 2);
            x  = ((x << 1) | fb) & 64'hFFFF_FFFF;
        end
        return s;
    endfunction

    function automatic longint unsigned get_res(int id);
        case (id)
            0:       return longint'(res_def);
            1:       return longint'(res_b3);
            2:       return longint'(res_b15);
            default: return longint'(res_b4);
        endcase
    endfunction

    task automatic check_output(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(int id, int due, longint unsigned val, string name);
        exp_t e;
        e.id = id; e.due = due; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    // Inputs change 2 time units after the falling edge, clear of the monitor
    task automatic tick(int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                check_output(sb[i].name, get_res(sb[i].id), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic apply_stimulus();
        int c;
        longint unsigned def_sum;
        def_sum = ref_sum(50);

        reset_n = 1'b0;
        start_v = '0;
        fin_v   = '0;
        tick(3);
        for (int i = 0; i < 4; i++) check_output($sformatf("reset_init_%0d", i), get_res(i), 0);
        reset_n = 1'b1;
        tick(2);

        // Three runs in parallel: CGES=3, CGES=15 and the default 32/50 config
        c = cyc;
        start_v[2:0] = 3'b111;
        tick(1);
        start_v[2:0] = 3'b000;
`ifndef TOP_RUNNING_RESULT_EN
        push_exp(1, c + 3, 0, "b3_before_done");
        push_exp(2, c + 15, 0, "b15_before_done");
        push_exp(0, c + 50, 0, "def_before_done");
`endif
        push_exp(1, c + 4, 7, "b3_sum");
        push_exp(2, c + 16, 120, "b15_sum");
        push_exp(0, c + 51, def_sum, "def_sum");
        push_exp(1, c + 60, 7, "b3_held");
        push_exp(2, c + 60, 120, "b15_held");
        push_exp(0, c + 60, def_sum, "def_held");
        tick(62);

        // Asynchronous reset in the middle of a second default run
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        tick(20);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check_output($sformatf("reset_async_%0d", i), get_res(i), 0);
        start_v = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 4; i++) push_exp(i, cyc + k * 1000, 0, $sformatf("reset_hold_%0d_%0d", i, k));
        end
        tick(3001);
        start_v = '0;
        reset_n = 1'b1;
        tick(2);
        check_output("b4_after_reset", get_res(3), 0);

        // fin together with start in IDLE must not launch a run
        c = cyc;
        start_v[3] = 1'b1;
        fin_v[3]   = 1'b1;
        tick(1);
        start_v[3] = 1'b0;
        fin_v[3]   = 1'b0;
        push_exp(3, c + 8, 0, "b4_fin_and_start");
        tick(10);

        // Abort on the second RUN cycle with no completed run yet
        c = cyc;
        start_v[3] = 1'b1;
        tick(2);
        fin_v[3]   = 1'b1;
        start_v[3] = 1'b0;
        tick(1);
        fin_v[3]   = 1'b0;
        push_exp(3, c + 3, ABORT_FRESH, "b4_abort_fresh");
        push_exp(3, c + 10, ABORT_FRESH, "b4_abort_fresh_hold");
        tick(12);

        // Full run with start held high afterwards
        c = cyc;
        start_v[3] = 1'b1;
`ifndef TOP_RUNNING_RESULT_EN
        push_exp(3, c + 4, ABORT_FRESH, "b4_before_done");
`endif
        push_exp(3, c + 5, 16, "b4_sum");
        tick(15);
        push_exp(3, cyc + 1, 16, "b4_no_retrigger");
        tick(2);

        // Drop start for one cycle then raise again
        start_v[3] = 1'b0;
        tick(1);
        c = cyc;
        start_v[3] = 1'b1;
        push_exp(3, c + 5, 16, "b4_rerun");
        tick(1);
        start_v[3] = 1'b0;
        tick(8);

        // Abort on the second RUN cycle after a completed run
        c = cyc;
        start_v[3] = 1'b1;
        tick(2);
        fin_v[3]   = 1'b1;
        start_v[3] = 1'b0;
        tick(1);
        fin_v[3]   = 1'b0;
        push_exp(3, c + 3, ABORT_AFTER, "b4_abort");
        push_exp(3, c + 10, ABORT_AFTER, "b4_abort_hold");
        tick(12);
    endtask

    initial begin
        apply_stimulus();
        for (int k = 0; k < 100 && sb.size() != 0; k++) tick(1);
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got pending, expected checked by cycle %0d", sb[i].name, sb[i].due);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
